// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port 8-bit RAM between requester A (CPU)
// and requester B (DMA/video). Contended cycles use round-robin with bursts
// of up to MAX_BURST back-to-back grants to one side while the other waits.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_x/we_x/addr_x/wdata_x request side x (x = a, b)
//   gnt_x                     combinational accept for side x
//   rdata_x/rvalid_x          read return, one cycle after a read grant
//   ram_we/ram_addr/ram_di    drive to the RAM
//   ram_do                    RAM read data (address of the previous cycle)
module ram_arbiter #(
    parameter int ADDR_BITS = 16,
    parameter int MAX_BURST = 1,
    parameter int CNT_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_a,
    input  logic                 we_a,
    input  logic [ADDR_BITS-1:0] addr_a,
    input  logic [7:0]           wdata_a,
    output logic                 gnt_a,
    output logic [7:0]           rdata_a,
    output logic                 rvalid_a,
    input  logic                 req_b,
    input  logic                 we_b,
    input  logic [ADDR_BITS-1:0] addr_b,
    input  logic [7:0]           wdata_b,
    output logic                 gnt_b,
    output logic [7:0]           rdata_b,
    output logic                 rvalid_b,
    output logic                 ram_we,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [7:0]           ram_di,
    input  logic [7:0]           ram_do
);

    localparam logic [0:0] SIDE_A = 1'b0;
    localparam logic [0:0] SIDE_B = 1'b1;

    localparam logic [CNT_BITS-1:0] MAX_C = CNT_BITS'(MAX_BURST);
    localparam logic [CNT_BITS-1:0] ONE_C = CNT_BITS'(1);

    logic [0:0]          last_q, last_d;
    logic [CNT_BITS-1:0] burst_q, burst_d;
    logic                rvalid_a_q, rvalid_a_d;
    logic                rvalid_b_q, rvalid_b_d;

    logic both;
    logic keep_last;
    logic pick_b;

    assign both = req_a & req_b;

    // The last side only keeps the RAM while it is inside an unbroken
    // burst. After an idle cycle (count 0) the other side wins, which is
    // what makes A win the first contended cycle out of reset (last = B).
    assign keep_last = (burst_q != '0) && (burst_q < MAX_C);

    always_comb begin
        pick_b = req_b;
        if (both) begin
            if (keep_last) begin
                pick_b = (last_q == SIDE_B);
            end else begin
                pick_b = (last_q == SIDE_A);
            end
        end
    end

    assign gnt_a = ~rst & req_a & ~pick_b;
    assign gnt_b = ~rst & req_b & pick_b;

    always_comb begin
        last_d  = last_q;
        burst_d = burst_q;
        if (gnt_a | gnt_b) begin
            if ((gnt_b ? SIDE_B : SIDE_A) == last_q) begin
                if (burst_q < MAX_C) begin
                    burst_d = burst_q + ONE_C;
                end
            end else begin
                last_d  = gnt_b ? SIDE_B : SIDE_A;
                burst_d = ONE_C;
            end
        end else begin
            burst_d = '0;
        end
    end

    assign rvalid_a_d = gnt_a & ~we_a;
    assign rvalid_b_d = gnt_b & ~we_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= SIDE_B;
            burst_q    <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            burst_q    <= burst_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
        end
    end

    assign ram_addr = gnt_b ? addr_b : addr_a;
    assign ram_di   = gnt_b ? wdata_b : wdata_a;
    assign ram_we   = (gnt_a & we_a) | (gnt_b & we_b);

    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
    assign rdata_a  = ram_do;
    assign rdata_b  = ram_do;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random checks of ram_arbiter with
// MAX_BURST = 1 and MAX_BURST = 4 instances, each with its own RAM.
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_a, we_a, req_b, we_b;
    logic [15:0] addr_a, addr_b;
    logic [7:0]  wdata_a, wdata_b;

    logic        gnt_a_w[2], gnt_b_w[2], rva_w[2], rvb_w[2], we_w[2];
    logic [7:0]  rda_w[2], rdb_w[2], di_w[2], do_w[2];
    logic [15:0] ad_w[2];

    ram_arbiter #(.ADDR_BITS(16), .MAX_BURST(1), .CNT_BITS(4)) u0 (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a_w[0]), .rdata_a(rda_w[0]), .rvalid_a(rva_w[0]),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b_w[0]), .rdata_b(rdb_w[0]), .rvalid_b(rvb_w[0]),
        .ram_we(we_w[0]), .ram_addr(ad_w[0]), .ram_di(di_w[0]),
        .ram_do(do_w[0])
    );

    ram_arbiter #(.ADDR_BITS(16), .MAX_BURST(4), .CNT_BITS(4)) u1 (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a_w[1]), .rdata_a(rda_w[1]), .rvalid_a(rva_w[1]),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b_w[1]), .rdata_b(rdb_w[1]), .rvalid_b(rvb_w[1]),
        .ram_we(we_w[1]), .ram_addr(ad_w[1]), .ram_di(di_w[1]),
        .ram_do(do_w[1])
    );

    function automatic logic [7:0] pre(int i);
        if (i == 256) return 8'h3C;
        return 8'(i) ^ 8'h5A;
    endfunction

    // Synchronous RAMs, read-first, preloaded on the first edge.
    logic [7:0] ram [2][512];
    bit loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 512; i++) begin
                ram[0][i] <= pre(i);
                ram[1][i] <= pre(i);
            end
            loaded <= 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                do_w[k] <= ram[k][ad_w[k][8:0]];
                if (we_w[k]) ram[k][ad_w[k][8:0]] <= di_w[k];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chks(string tag, string obs, string exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %s expected %s", tag, obs, exp);
        end
    endtask

    // Reference model: who holds the RAM, how long its current unbroken
    // run of grants is, and what each requester should see back.
    bit         mlast[2];
    int         mrun[2];
    bit         erva[2], ervb[2];
    logic [7:0] erda[2], erdb[2];
    logic [7:0] mmem[2][512];
    string      hist[2];
    bit         lga, lgb;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mlast[k] = 1'b1;
            mrun[k]  = 0;
            erva[k]  = 1'b0;
            ervb[k]  = 1'b0;
        end
        lga = 1'b0;
        lgb = 1'b0;
    endtask

    task automatic cycle();
        bit ga, gb, side;
        int mb;
        #2;
        for (int k = 0; k < 2; k++) begin
            mb = (k == 0) ? 1 : 4;
            ga = 1'b0;
            gb = 1'b0;
            if (req_a && !req_b) ga = 1'b1;
            else if (req_b && !req_a) gb = 1'b1;
            else if (req_a && req_b) begin
                if (mrun[k] > 0 && mrun[k] < mb) begin
                    if (mlast[k]) gb = 1'b1; else ga = 1'b1;
                end else begin
                    if (mlast[k]) ga = 1'b1; else gb = 1'b1;
                end
            end
            chk("gnt_a", gnt_a_w[k], ga);
            chk("gnt_b", gnt_b_w[k], gb);
            chk("gnt_excl", gnt_a_w[k] & gnt_b_w[k], 0);
            chk("ram_we", we_w[k], (ga & we_a) | (gb & we_b));
            if (ga) chk("ram_addr", ad_w[k], addr_a);
            if (gb) chk("ram_addr", ad_w[k], addr_b);
            if (ga && we_a) chk("ram_di", di_w[k], wdata_a);
            if (gb && we_b) chk("ram_di", di_w[k], wdata_b);
            chk("rvalid_a", rva_w[k], erva[k]);
            chk("rvalid_b", rvb_w[k], ervb[k]);
            if (erva[k]) chk("rdata_a", rda_w[k], erda[k]);
            if (ervb[k]) chk("rdata_b", rdb_w[k], erdb[k]);
            if (ga) hist[k] = {hist[k], "A"};
            else if (gb) hist[k] = {hist[k], "B"};
            else hist[k] = {hist[k], "-"};
            erva[k] = ga & !we_a;
            ervb[k] = gb & !we_b;
            erda[k] = mmem[k][addr_a[8:0]];
            erdb[k] = mmem[k][addr_b[8:0]];
            if (ga && we_a) mmem[k][addr_a[8:0]] = wdata_a;
            if (gb && we_b) mmem[k][addr_b[8:0]] = wdata_b;
            if (ga || gb) begin
                side = gb;
                if (side == mlast[k]) begin
                    if (mrun[k] < mb) mrun[k]++;
                end else begin
                    mlast[k] = side;
                    mrun[k]  = 1;
                end
            end else begin
                mrun[k] = 0;
            end
            if (k == 0) begin
                lga = ga;
                lgb = gb;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        for (int k = 0; k < 2; k++) begin
            chk("rst_gnt_a", gnt_a_w[k], 0);
            chk("rst_gnt_b", gnt_b_w[k], 0);
            chk("rst_ram_we", we_w[k], 0);
            chk("rst_rvalid_a", rva_w[k], 0);
            chk("rst_rvalid_b", rvb_w[k], 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle();
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mmem[0][i] = pre(i);
            mmem[1][i] = pre(i);
        end
        rst = 1'b1;
        req_a = 1'b1; we_a = 1'b1; addr_a = 16'h0; wdata_a = 8'h0;
        req_b = 1'b1; we_b = 1'b1; addr_b = 16'h0; wdata_b = 8'h0;
        #1;
        chk_reset_outputs();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Contended reads straight after reset.
        we_a = 1'b0; addr_a = 16'h0001;
        we_b = 1'b0; addr_b = 16'h0002;
        hist[0] = "";
        hist[1] = "";
        for (int n = 0; n < 12; n++) cycle();
        chks("alt_mb1", hist[0].substr(0, 5), "ABABAB");
        chks("burst_mb4", hist[1], "AAAABBBBAAAA");
        idle();
        cycle();

        // A alone: write then read back.
        req_a = 1'b1; we_a = 1'b1; addr_a = 16'h0010; wdata_a = 8'hA5;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t1_wr_gnt", gnt_a_w[k], 1);
            chk("t1_wr_we", we_w[k], 1);
        end
        cycle();
        we_a = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t1_rd_gnt", gnt_a_w[k], 1);
            chk("t1_rd_we", we_w[k], 0);
        end
        cycle();
        idle();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t1_rvalid", rva_w[k], 1);
            chk("t1_rdata", rda_w[k], 8'hA5);
        end
        cycle();

        // Reset while a read returns and A is writing.
        req_a = 1'b1; we_a = 1'b0; addr_a = 16'h0010;
        cycle();
        we_a = 1'b1; wdata_a = 8'h77;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t5_pre_rvalid", rva_w[k], 1);
            chk("t5_pre_we", we_w[k], 1);
        end
        do_reset();
        req_a = 1'b1; we_a = 1'b0;
        req_b = 1'b1; we_b = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) chk("t5_first_a", gnt_a_w[k], 1);
        cycle();
        idle();
        cycle();

        // Same-cycle write by A and read by B of one address.
        do_reset();
        req_a = 1'b1; we_a = 1'b1; addr_a = 16'h0020; wdata_a = 8'h11;
        req_b = 1'b1; we_b = 1'b0; addr_b = 16'h0020;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t4_gnt_a", gnt_a_w[k], 1);
            chk("t4_gnt_b0", gnt_b_w[k], 0);
        end
        cycle();
        req_a = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) chk("t4_gnt_b1", gnt_b_w[k], 1);
        cycle();
        req_b = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t4_rvalid_b", rvb_w[k], 1);
            chk("t4_rdata_b", rdb_w[k], 8'h11);
        end
        cycle();

        // B single read of preloaded data, then idle.
        req_b = 1'b1; we_b = 1'b0; addr_b = 16'h0100;
        cycle();
        idle();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t6_rvalid_b", rvb_w[k], 1);
            chk("t6_rdata_b", rdb_w[k], 8'h3C);
            chk("t6_rvalid_a", rva_w[k], 0);
        end
        cycle();
        for (int k = 0; k < 2; k++) chk("t6_rvalid_b_off", rvb_w[k], 0);
        req_a = 1'b1; we_a = 1'b0;
        req_b = 1'b1; we_b = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) chk("t6_cnt_cleared", gnt_a_w[k], 1);
        cycle();
        idle();
        cycle();

        // Random traffic with held requests and occasional abandons.
        lga = 1'b0;
        lgb = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            if (!req_a || lga) begin
                req_a   = ($urandom % 4) != 0;
                we_a    = 1'($urandom % 2);
                addr_a  = 16'($urandom_range(0, 15));
                wdata_a = 8'($urandom);
            end else if ($urandom % 16 == 0) begin
                req_a = 1'b0;
            end
            if (!req_b || lgb) begin
                req_b   = ($urandom % 4) != 0;
                we_b    = 1'($urandom % 2);
                addr_b  = 16'($urandom_range(0, 15));
                wdata_b = 8'($urandom);
            end else if ($urandom % 16 == 0) begin
                req_b = 1'b0;
            end
            cycle();
        end
        idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
